// File: rtl/i2c_byte_ctrl_pkg.sv
// i2c_byte_ctrl_pkg: bit-level command codes and byte FSM states
// shared by the I2C byte sequencer and its bit-level partner.
package i2c_byte_ctrl_pkg;

    localparam logic [3:0] CMD_NOP   = 4'b0000;
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_STOP  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b1000;

    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_START = 6'b000010,
        ST_WRITE = 6'b000100,
        ST_READ  = 6'b001000,
        ST_ACK   = 6'b010000,
        ST_STOP  = 6'b100000
    } st_e;

endpackage

// File: rtl/i2c_byte_ctrl_if.sv
// i2c_byte_ctrl_if: host request/response and bit-level command bus
// seen by the byte sequencer (slave) and its driver (master).
interface i2c_byte_ctrl_if;

    logic       start;
    logic       stop;
    logic       read;
    logic       write;
    logic       ack_in;
    logic [7:0] din;
    logic       cmd_ack;
    logic       ack_out;
    logic [7:0] dout;
    logic       i2c_busy;
    logic       i2c_al;
    logic [3:0] core_cmd;
    logic       core_txd;
    logic       core_ack;
    logic       core_rxd;
    logic       bit_al;
    logic       bit_busy;

    modport slave (
        input  start, stop, read, write, ack_in, din,
        input  core_ack, core_rxd, bit_al, bit_busy,
        output cmd_ack, ack_out, dout, i2c_busy, i2c_al,
        output core_cmd, core_txd
    );

    modport master (
        output start, stop, read, write, ack_in, din,
        output core_ack, core_rxd, bit_al, bit_busy,
        input  cmd_ack, ack_out, dout, i2c_busy, i2c_al,
        input  core_cmd, core_txd
    );

endinterface

// File: rtl/i2c_byte_ctrl.sv
// i2c_byte_ctrl: expands one host byte request into START/WRITE/READ/
// ACK/STOP bit commands, each held until the bit engine acknowledges it.
module i2c_byte_ctrl
    import i2c_byte_ctrl_pkg::*;
#(
    parameter bit STOP_ON_NACK = 1'b0
) (
    input  logic          clk,
    input  logic          nReset,
    input  logic          rst,
    i2c_byte_ctrl_if.slave bus
);

    st_e        r_state, w_state_nx;
    logic [3:0] r_cmd, w_cmd_nx;
    logic [7:0] r_sr, w_sr_nx;
    logic [2:0] r_cnt, w_cnt_nx;
    logic       r_ack_out, w_ack_out_nx;
    logic       r_cmd_ack, w_cmd_ack_nx;
    logic       r_busy;
    logic       r_al;
    logic       w_go;
    logic       w_nack_stop;

    assign w_go = (bus.read | bus.write | bus.stop) & ~r_cmd_ack;
    assign w_nack_stop = STOP_ON_NACK & bus.write & bus.core_rxd;

    always_comb begin
        w_state_nx   = r_state;
        w_cmd_nx     = r_cmd;
        w_sr_nx      = r_sr;
        w_cnt_nx     = r_cnt;
        w_ack_out_nx = r_ack_out;
        w_cmd_ack_nx = 1'b0;
        if (bus.bit_al) begin
            w_state_nx = ST_IDLE;
            w_cmd_nx   = CMD_NOP;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        w_sr_nx  = bus.din;
                        w_cnt_nx = 3'd7;
                        priority case (1'b1)
                            bus.start: begin
                                w_state_nx = ST_START;
                                w_cmd_nx   = CMD_START;
                            end
                            bus.read: begin
                                w_state_nx = ST_READ;
                                w_cmd_nx   = CMD_READ;
                            end
                            bus.write: begin
                                w_state_nx = ST_WRITE;
                                w_cmd_nx   = CMD_WRITE;
                            end
                            default: begin
                                w_state_nx = ST_STOP;
                                w_cmd_nx   = CMD_STOP;
                            end
                        endcase
                    end
                end
                ST_START: begin
                    if (bus.core_ack) begin
                        if (bus.read) begin
                            w_state_nx = ST_READ;
                            w_cmd_nx   = CMD_READ;
                        end else begin
                            w_state_nx = ST_WRITE;
                            w_cmd_nx   = CMD_WRITE;
                        end
                    end
                end
                ST_WRITE, ST_READ: begin
                    if (bus.core_ack) begin
                        w_sr_nx  = {r_sr[6:0], bus.core_rxd};
                        w_cnt_nx = r_cnt - 3'd1;
                        // ACK phase reverses direction relative to the data bits
                        if (r_cnt == 3'd0) begin
                            w_state_nx = ST_ACK;
                            w_cmd_nx   = bus.read ? CMD_WRITE : CMD_READ;
                        end
                    end
                end
                ST_ACK: begin
                    if (bus.core_ack) begin
                        w_ack_out_nx = bus.core_rxd;
                        if (bus.stop | w_nack_stop) begin
                            w_state_nx = ST_STOP;
                            w_cmd_nx   = CMD_STOP;
                        end else begin
                            w_state_nx   = ST_IDLE;
                            w_cmd_nx     = CMD_NOP;
                            w_cmd_ack_nx = 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bus.core_ack) begin
                        w_state_nx   = ST_IDLE;
                        w_cmd_nx     = CMD_NOP;
                        w_cmd_ack_nx = 1'b1;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_cmd_nx   = CMD_NOP;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state   <= ST_IDLE;
            r_cmd     <= CMD_NOP;
            r_sr      <= 8'h00;
            r_cnt     <= 3'd0;
            r_ack_out <= 1'b0;
            r_cmd_ack <= 1'b0;
            r_busy    <= 1'b0;
            r_al      <= 1'b0;
        end else if (rst) begin
            r_state   <= ST_IDLE;
            r_cmd     <= CMD_NOP;
            r_sr      <= 8'h00;
            r_cnt     <= 3'd0;
            r_ack_out <= 1'b0;
            r_cmd_ack <= 1'b0;
            r_busy    <= 1'b0;
            r_al      <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cmd     <= w_cmd_nx;
            r_sr      <= w_sr_nx;
            r_cnt     <= w_cnt_nx;
            r_ack_out <= w_ack_out_nx;
            r_cmd_ack <= w_cmd_ack_nx;
            r_busy    <= bus.bit_busy;
            r_al      <= bus.bit_al;
        end
    end

    // In the ACK phase the driven bit is the host's ACK/NACK choice
    assign bus.core_txd = (r_state == ST_WRITE) ? r_sr[7] :
                          ((r_state == ST_ACK) & bus.ack_in);
    assign bus.core_cmd = r_cmd;
    assign bus.dout     = r_sr;
    assign bus.ack_out  = r_ack_out;
    assign bus.cmd_ack  = r_cmd_ack;
    assign bus.i2c_busy = r_busy;
    assign bus.i2c_al   = r_al;

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// tb_i2c_byte_ctrl: directed scenarios against a behavioural bit engine
// that acks each command after a fixed delay and logs what it saw.
module tb_i2c_byte_ctrl;
    import i2c_byte_ctrl_pkg::*;

    localparam int DLY = 2;
    localparam logic [4:0] E_ST = {CMD_START, 1'b0};
    localparam logic [4:0] E_W0 = {CMD_WRITE, 1'b0};
    localparam logic [4:0] E_W1 = {CMD_WRITE, 1'b1};
    localparam logic [4:0] E_RD = {CMD_READ, 1'b0};
    localparam logic [4:0] E_SP = {CMD_STOP, 1'b0};

    logic clk = 1'b0;
    logic nReset = 1'b0;
    logic rst = 1'b0;
    int n_cmp = 0;
    int n_err = 0;

    i2c_byte_ctrl_if bus ();
    i2c_byte_ctrl_if bus2 ();

    i2c_byte_ctrl #(.STOP_ON_NACK(1'b0)) u_dut (
        .clk(clk), .nReset(nReset), .rst(rst), .bus(bus)
    );
    i2c_byte_ctrl #(.STOP_ON_NACK(1'b1)) u_dut2 (
        .clk(clk), .nReset(nReset), .rst(rst), .bus(bus2)
    );

    always #5 clk = ~clk;

    logic [63:0] log_vec, log2_vec;
    int log_n, log2_n;
    logic rx_q[$];
    logic rx2_q[$];
    int wr_acks = 0;
    int al_arm = 0;
    bit mdl_off = 1'b0;

    initial begin : bit_model
        int dly;
        dly = 0;
        forever begin
            @(negedge clk);
            if (!mdl_off) begin
                bus.core_ack = 1'b0;
                bus.bit_al = 1'b0;
                if (bus.core_cmd != CMD_NOP) begin
                    if (dly >= DLY) begin
                        dly = 0;
                        bus.core_ack = 1'b1;
                        if (bus.core_cmd == CMD_WRITE) begin
                            bus.core_rxd = bus.core_txd;
                            wr_acks++;
                            if (wr_acks == al_arm) bus.bit_al = 1'b1;
                        end else if (bus.core_cmd == CMD_READ)
                            bus.core_rxd = (rx_q.size() > 0) ? rx_q.pop_front() : 1'b0;
                        else
                            bus.core_rxd = 1'b0;
                        log_vec = {log_vec[58:0], bus.core_cmd, bus.core_txd};
                        log_n++;
                    end else dly++;
                end else dly = 0;
            end
        end
    end

    initial begin : bit_model2
        int dly;
        dly = 0;
        forever begin
            @(negedge clk);
            bus2.core_ack = 1'b0;
            if (bus2.core_cmd != CMD_NOP) begin
                if (dly >= DLY) begin
                    dly = 0;
                    bus2.core_ack = 1'b1;
                    if (bus2.core_cmd == CMD_WRITE)
                        bus2.core_rxd = bus2.core_txd;
                    else if (bus2.core_cmd == CMD_READ)
                        bus2.core_rxd = (rx2_q.size() > 0) ? rx2_q.pop_front() : 1'b0;
                    else
                        bus2.core_rxd = 1'b0;
                    log2_vec = {log2_vec[58:0], bus2.core_cmd, bus2.core_txd};
                    log2_n++;
                end else dly++;
            end else dly = 0;
        end
    end

    task automatic req(input logic s, p, r, w, a, input logic [7:0] d,
                       output bit got, output logic after);
        @(negedge clk);
        log_vec = '0;
        log_n = 0;
        wr_acks = 0;
        bus.start = s; bus.stop = p; bus.read = r;
        bus.write = w; bus.ack_in = a; bus.din = d;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (bus.cmd_ack) got = 1'b1;
        end
        bus.start = 0; bus.stop = 0; bus.read = 0; bus.write = 0;
        @(negedge clk);
        after = bus.cmd_ack;
    endtask

    task automatic test_reset();
        bus.bit_busy = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.cmd_ack, bus.ack_out, bus.dout, bus.i2c_busy, bus.i2c_al,
             bus.core_cmd, bus.core_txd} !== 17'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0",
                {bus.cmd_ack, bus.ack_out, bus.dout, bus.i2c_busy,
                 bus.i2c_al, bus.core_cmd, bus.core_txd});
        end
        nReset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_start_write();
        bit got; logic after;
        logic [63:0] exp;
        rx_q = {1'b0};
        req(1, 0, 0, 1, 0, 8'hA0, got, after);
        exp = {E_ST, E_W1, E_W0, E_W1, E_W0, E_W0, E_W0, E_W0, E_W0, E_RD};
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL t1_cmd_ack: got none want pulse"); end
        n_cmp++;
        if (after !== 1'b0) begin n_err++; $display("FAIL t1_pulse_len: got %b want 0", after); end
        n_cmp++;
        if (log_n != 10 || log_vec !== exp) begin
            n_err++;
            $display("FAIL t1_cmd_seq: got %0d/%h want 10/%h", log_n, log_vec, exp);
        end
        n_cmp++;
        if (bus.ack_out !== 1'b0) begin n_err++; $display("FAIL t1_ack_out: got %b want 0", bus.ack_out); end
        n_cmp++;
        if (bus.dout !== 8'hA0) begin n_err++; $display("FAIL t1_dout: got %h want a0", bus.dout); end
        n_cmp++;
        if (bus.i2c_busy !== 1'b1) begin n_err++; $display("FAIL t1_busy: got %b want 1", bus.i2c_busy); end
    endtask

    task automatic test_read_stop();
        bit got; logic after;
        logic [63:0] exp;
        rx_q = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        req(0, 1, 1, 0, 1, 8'h00, got, after);
        exp = {E_RD, E_RD, E_RD, E_RD, E_RD, E_RD, E_RD, E_RD, E_W1, E_SP};
        n_cmp++;
        if (!got || after !== 1'b0) begin
            n_err++;
            $display("FAIL t2_cmd_ack: got %b/%b want 1/0", got, after);
        end
        n_cmp++;
        if (log_n != 10 || log_vec !== exp) begin
            n_err++;
            $display("FAIL t2_cmd_seq: got %0d/%h want 10/%h", log_n, log_vec, exp);
        end
        n_cmp++;
        if (bus.dout !== 8'h5A) begin n_err++; $display("FAIL t2_dout: got %h want 5a", bus.dout); end
        bus.bit_busy = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.i2c_busy !== 1'b0) begin n_err++; $display("FAIL t2_busy_fall: got %b want 0", bus.i2c_busy); end
        bus.bit_busy = 1'b1;
    endtask

    task automatic test_arb_lost();
        bit seen;
        @(negedge clk);
        log_vec = '0; log_n = 0; wr_acks = 0; al_arm = 3;
        bus.write = 1'b1; bus.din = 8'hFF; bus.ack_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.i2c_al) seen = 1'b1;
        end
        bus.write = 1'b0;
        al_arm = 0;
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL t3_al: got 0 want 1"); end
        n_cmp++;
        if (bus.core_cmd !== CMD_NOP || bus.cmd_ack !== 1'b0) begin
            n_err++;
            $display("FAIL t3_idle: got cmd %h ack %b want 0/0", bus.core_cmd, bus.cmd_ack);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.cmd_ack || bus.core_cmd != CMD_NOP) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin n_err++; $display("FAIL t3_quiet: got activity want none"); end
    endtask

    task automatic test_stop_on_nack();
        bit got; logic after;
        logic [63:0] exp;
        rx_q = {1'b1};
        req(0, 0, 0, 1, 0, 8'h55, got, after);
        exp = {E_W0, E_W1, E_W0, E_W1, E_W0, E_W1, E_W0, E_W1, E_RD};
        n_cmp++;
        if (!got || log_n != 9 || log_vec !== exp) begin
            n_err++;
            $display("FAIL t4_no_stop_seq: got %b %0d/%h want 1 9/%h", got, log_n, log_vec, exp);
        end
        n_cmp++;
        if (bus.ack_out !== 1'b1) begin n_err++; $display("FAIL t4_ack_out: got %b want 1", bus.ack_out); end
        rx2_q = {1'b1};
        log2_vec = '0; log2_n = 0;
        @(negedge clk);
        bus2.write = 1'b1; bus2.din = 8'h55; bus2.ack_in = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (bus2.cmd_ack) got = 1'b1;
        end
        bus2.write = 1'b0;
        exp = {E_W0, E_W1, E_W0, E_W1, E_W0, E_W1, E_W0, E_W1, E_RD, E_SP};
        n_cmp++;
        if (!got || log2_n != 10 || log2_vec !== exp) begin
            n_err++;
            $display("FAIL t4_nack_stop_seq: got %b %0d/%h want 1 10/%h", got, log2_n, log2_vec, exp);
        end
        n_cmp++;
        if (bus2.ack_out !== 1'b1) begin n_err++; $display("FAIL t4_ack_out2: got %b want 1", bus2.ack_out); end
    endtask

    task automatic test_sync_rst();
        bit got; logic after;
        logic [63:0] exp;
        @(negedge clk);
        wr_acks = 0;
        bus.write = 1'b1; bus.din = 8'hC3; bus.ack_in = 1'b0;
        for (int i = 0; i < 200 && wr_acks < 4; i++) @(negedge clk);
        rst = 1'b1;
        bus.write = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.cmd_ack, bus.ack_out, bus.dout, bus.i2c_busy, bus.i2c_al,
             bus.core_cmd, bus.core_txd} !== 17'h0) begin
            n_err++;
            $display("FAIL t5_rst_outputs: got %h want 0",
                {bus.cmd_ack, bus.ack_out, bus.dout, bus.i2c_busy,
                 bus.i2c_al, bus.core_cmd, bus.core_txd});
        end
        rst = 1'b0;
        rx_q = {1'b0};
        req(1, 0, 0, 1, 0, 8'h3C, got, after);
        exp = {E_ST, E_W0, E_W0, E_W1, E_W1, E_W1, E_W1, E_W0, E_W0, E_RD};
        n_cmp++;
        if (!got || log_n != 10 || log_vec !== exp) begin
            n_err++;
            $display("FAIL t5_after_rst_seq: got %b %0d/%h want 1 10/%h", got, log_n, log_vec, exp);
        end
        n_cmp++;
        if (bus.dout !== 8'h3C) begin n_err++; $display("FAIL t5_dout: got %h want 3c", bus.dout); end
    endtask

    task automatic test_read_prio_stop_only();
        bit got; logic after;
        logic [63:0] exp;
        rx_q = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        req(0, 0, 1, 1, 1, 8'hFF, got, after);
        exp = {E_RD, E_RD, E_RD, E_RD, E_RD, E_RD, E_RD, E_RD, E_W1};
        n_cmp++;
        if (!got || log_n != 9 || log_vec !== exp) begin
            n_err++;
            $display("FAIL t6_read_wins: got %b %0d/%h want 1 9/%h", got, log_n, log_vec, exp);
        end
        n_cmp++;
        if (bus.dout !== 8'h96 || bus.ack_out !== 1'b1) begin
            n_err++;
            $display("FAIL t6_dout_ack: got %h/%b want 96/1", bus.dout, bus.ack_out);
        end
        req(0, 1, 0, 0, 0, 8'h00, got, after);
        n_cmp++;
        if (!got || after !== 1'b0 || log_n != 1 || log_vec !== {59'd0, E_SP}) begin
            n_err++;
            $display("FAIL t6_stop_only: got %b/%b %0d/%h want 1/0 1/%h", got, after, log_n, log_vec, E_SP);
        end
        n_cmp++;
        if (bus.ack_out !== 1'b1) begin n_err++; $display("FAIL t6_ack_kept: got %b want 1", bus.ack_out); end
    endtask

    task automatic test_idle_ack();
        bit seen;
        mdl_off = 1'b1;
        @(negedge clk);
        bus.din = 8'hAA;
        bus.core_ack = 1'b1;
        bus.core_rxd = 1'b1;
        @(negedge clk);
        bus.core_ack = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.cmd_ack || bus.core_cmd != CMD_NOP) seen = 1'b1;
        end
        mdl_off = 1'b0;
        n_cmp++;
        if (seen || bus.dout !== 8'h00) begin
            n_err++;
            $display("FAIL t7_idle_ack: got act %b dout %h want 0/00", seen, bus.dout);
        end
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.read = 0; bus.write = 0;
        bus.ack_in = 0; bus.din = 0; bus.core_ack = 0; bus.core_rxd = 0;
        bus.bit_al = 0; bus.bit_busy = 0;
        bus2.start = 0; bus2.stop = 0; bus2.read = 0; bus2.write = 0;
        bus2.ack_in = 0; bus2.din = 0; bus2.core_rxd = 0;
        bus2.bit_al = 0; bus2.bit_busy = 0;
        bus2.core_ack = 0;
        log_vec = '0; log_n = 0; log2_vec = '0; log2_n = 0;
        test_reset();
        test_start_write();
        test_read_stop();
        test_arb_lost();
        test_stop_on_nack();
        test_sync_rst();
        test_read_prio_stop_only();
        test_idle_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
